// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
// The request is held with a stable address until imem_ready; imem_rdata is valid only when imem_req & imem_ready.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC, IF/ID register, one-entry skid buffer and a FETCH/HOLD/DRAIN FSM.
// Optional macro FETCH_PERF_CNT_EN adds stall_cycles and fetch_count outputs.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pc_stall,
   input  logic          ifid_stall,
   input  logic          branch_taken,
   input  logic [31:0]   branch_target,
   fetch_stage_if.master bus,
   output logic [31:0]   pc_IF_ID,
   output logic [31:0]   inst_IF_ID,
   output logic          valid_IF_ID,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]   stall_cycles,
   output logic [31:0]   fetch_count,
`endif
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        hold;
   logic [31:0] target;

   assign hold   = pc_stall | ifid_stall;
   assign target = branch_target & ~32'h3;

   // DRAIN keeps presenting the abandoned address so the outstanding request completes unchanged.
   assign bus.imem_req  = (state_q != HOLD);
   assign bus.imem_addr = (state_q == DRAIN) ? pend_q : pc_q;

   assign pc_IF_ID    = ifid_pc_q;
   assign inst_IF_ID  = ifid_inst_q;
   assign valid_IF_ID = ifid_valid_q;
   assign state_dbg   = state_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_d       = pend_q;
      skid_d       = skid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
      case (state_q)
         FETCH: begin
            if (branch_taken) begin
               pc_d         = target;
               ifid_pc_d    = 32'h0;
               ifid_inst_d  = NOP_INST;
               ifid_valid_d = 1'b0;
               if (!bus.imem_ready) begin
                  pend_d  = pc_q;
                  state_d = DRAIN;
               end
            end else if (bus.imem_ready && !hold) begin
               ifid_pc_d    = pc_q;
               ifid_inst_d  = bus.imem_rdata;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
            end else if (bus.imem_ready) begin
               skid_d  = bus.imem_rdata;
               state_d = HOLD;
            end else if (!hold) begin
               ifid_pc_d    = 32'h0;
               ifid_inst_d  = NOP_INST;
               ifid_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               pc_d         = target;
               skid_d       = 32'h0;
               ifid_pc_d    = 32'h0;
               ifid_inst_d  = NOP_INST;
               ifid_valid_d = 1'b0;
               state_d      = FETCH;
            end else if (!hold) begin
               ifid_pc_d    = pc_q;
               ifid_inst_d  = skid_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
               state_d      = FETCH;
            end
         end
         DRAIN: begin
            // IF/ID already holds a bubble; a further redirect only moves pc.
            if (branch_taken) pc_d = target;
            if (bus.imem_ready) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         pend_q       <= 32'h0;
         skid_q       <= 32'h0;
         ifid_pc_q    <= 32'h0;
         ifid_inst_q  <= NOP_INST;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_q       <= pend_d;
         skid_q       <= skid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q, fetch_q;
   logic        fetch_load;

   // A valid write into IF/ID happens only from FETCH (direct) or HOLD (skid drain).
   assign fetch_load   = ifid_valid_d && ((state_q == FETCH && bus.imem_ready && !hold && !branch_taken) ||
                                          (state_q == HOLD && !hold && !branch_taken));
   assign stall_cycles = stall_q;
   assign fetch_count  = fetch_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 32'h0;
         fetch_q <= 32'h0;
      end else begin
         if (hold)       stall_q <= stall_q + 32'd1;
         if (fetch_load) fetch_q <= fetch_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns (address ^ salt) so fetched words are predictable.
// Build with FETCH_PERF_CNT_EN defined to also exercise the counters.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_stall = 1'b0;
   logic        ifid_stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] pc_IF_ID, inst_IF_ID;
   logic        valid_IF_ID;
   logic [1:0]  state_dbg;
   logic [31:0] salt = 32'hA000_0000;
   int          checks = 0;
   int          errors = 0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles, fetch_count;
`endif

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0]  S_FETCH = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2;

   fetch_stage_if bus ();

   assign bus.imem_rdata = bus.imem_addr ^ salt;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .pc_stall      (pc_stall),
      .ifid_stall    (ifid_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .bus           (bus.master),
      .pc_IF_ID      (pc_IF_ID),
      .inst_IF_ID    (inst_IF_ID),
      .valid_IF_ID   (valid_IF_ID),
`ifdef FETCH_PERF_CNT_EN
      .stall_cycles  (stall_cycles),
      .fetch_count   (fetch_count),
`endif
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
      chk({tag, "_pc"}, pc_IF_ID, pc);
      chk({tag, "_inst"}, inst_IF_ID, inst);
      chk({tag, "_valid"}, {31'h0, valid_IF_ID}, {31'h0, v});
   endtask

   initial begin
      bus.imem_ready = 1'b1;
      step();
      rst = 1'b0;
      chk_ifid("reset", 32'h0, NOP, 1'b0);
      chk("reset_state", {30'h0, state_dbg}, {30'h0, S_FETCH});
      chk("reset_addr", bus.imem_addr, 32'h0);
      chk("reset_req", {31'h0, bus.imem_req}, 32'h1);

      // Streaming, one instruction per cycle
      step(); chk_ifid("s0", 32'h0, 32'hA000_0000, 1'b1);
      step(); chk_ifid("s1", 32'h4, 32'hA000_0004, 1'b1);
      step(); chk_ifid("s2", 32'h8, 32'hA000_0008, 1'b1);
      step(); chk_ifid("s3", 32'hC, 32'hA000_000C, 1'b1);
      chk("s3_addr", bus.imem_addr, 32'h10);

      // Hold at pc=8 for three cycles, then release
      rst = 1'b1; step(); rst = 1'b0;
      step(); step();
      chk("h_addr", bus.imem_addr, 32'h8);
      pc_stall = 1'b1;
      step();
      chk("h1_state", {30'h0, state_dbg}, {30'h0, S_HOLD});
      chk("h1_req", {31'h0, bus.imem_req}, 32'h0);
      chk_ifid("h1", 32'h4, 32'hA000_0004, 1'b1);
      salt = 32'hB000_0000;
      pc_stall = 1'b0; ifid_stall = 1'b1;
      step();
      chk("h2_state", {30'h0, state_dbg}, {30'h0, S_HOLD});
      chk("h2_pc", pc_IF_ID, 32'h4);
      pc_stall = 1'b1; ifid_stall = 1'b0;
      step();
      chk("h3_state", {30'h0, state_dbg}, {30'h0, S_HOLD});
      chk("h3_req", {31'h0, bus.imem_req}, 32'h0);
      pc_stall = 1'b0;
      step();
      salt = 32'hA000_0000;
      chk_ifid("hrel", 32'h8, 32'hA000_0008, 1'b1);
      chk("hrel_state", {30'h0, state_dbg}, {30'h0, S_FETCH});
      chk("hrel_addr", bus.imem_addr, 32'hC);

      // Branch together with hold: flush wins
      pc_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
      step();
      pc_stall = 1'b0; branch_taken = 1'b0;
      chk("br_addr", bus.imem_addr, 32'h100);
      chk_ifid("br", 32'h0, NOP, 1'b0);
      chk("br_state", {30'h0, state_dbg}, {30'h0, S_FETCH});
      step(); chk_ifid("br_next", 32'h100, 32'hA000_0100, 1'b1);

      // Branch to 0x12 checks target low bits are dropped
      branch_taken = 1'b1; branch_target = 32'h12;
      step();
      branch_taken = 1'b0;
      chk("al_addr", bus.imem_addr, 32'h10);

      // Branch while waiting at 0x10: drain old request
      bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
      step();
      branch_taken = 1'b0;
      chk("dr1_state", {30'h0, state_dbg}, {30'h0, S_DRAIN});
      chk("dr1_addr", bus.imem_addr, 32'h10);
      chk("dr1_req", {31'h0, bus.imem_req}, 32'h1);
      chk("dr1_valid", {31'h0, valid_IF_ID}, 32'h0);
      step();
      chk("dr2_addr", bus.imem_addr, 32'h10);
      bus.imem_ready = 1'b1;
      step();
      chk("dr3_state", {30'h0, state_dbg}, {30'h0, S_FETCH});
      chk("dr3_addr", bus.imem_addr, 32'h200);
      chk("dr3_valid", {31'h0, valid_IF_ID}, 32'h0);
      step(); chk_ifid("dr4", 32'h200, 32'hA000_0200, 1'b1);

      // Not ready: bubble without hold, freeze with hold
      bus.imem_ready = 1'b0;
      step(); chk_ifid("nr1", 32'h0, NOP, 1'b0);
      chk("nr1_addr", bus.imem_addr, 32'h204);
      bus.imem_ready = 1'b1;
      step(); chk_ifid("nr2", 32'h204, 32'hA000_0204, 1'b1);
      bus.imem_ready = 1'b0; ifid_stall = 1'b1;
      step(); chk_ifid("nr3", 32'h204, 32'hA000_0204, 1'b1);
      chk("nr3_addr", bus.imem_addr, 32'h208);
      ifid_stall = 1'b0;
      step(); chk("nr4_valid", {31'h0, valid_IF_ID}, 32'h0);

      // PC wraparound
      bus.imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      step();
      branch_taken = 1'b0;
      chk("wr1_addr", bus.imem_addr, 32'hFFFF_FFFC);
      step();
      chk_ifid("wr2", 32'hFFFF_FFFC, 32'h5FFF_FFFC, 1'b1);
      chk("wr2_addr", bus.imem_addr, 32'h0);

      // Reset overrides DRAIN
      bus.imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
      step();
      branch_taken = 1'b0;
      chk("rd_state", {30'h0, state_dbg}, {30'h0, S_DRAIN});
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rd_rst_state", {30'h0, state_dbg}, {30'h0, S_FETCH});
      chk("rd_rst_addr", bus.imem_addr, 32'h0);
      chk_ifid("rd_rst", 32'h0, NOP, 1'b0);

`ifdef FETCH_PERF_CNT_EN
      bus.imem_ready = 1'b1;
      chk("pc_init_fetch", fetch_count, 32'h0);
      repeat (5) step();
      pc_stall = 1'b1;
      repeat (2) step();
      pc_stall = 1'b0;
      chk("pc_fetch", fetch_count, 32'd5);
      chk("pc_stall", stall_cycles, 32'd2);
      rst = 1'b1; step(); rst = 1'b0;
      chk("pc_rst_fetch", fetch_count, 32'h0);
      chk("pc_rst_stall", stall_cycles, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), bubble instruction placed in IF/ID.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pc_stall  in  1  hazard-unit request to hold PC.
REQ-006 ifid_stall  in  1  hazard-unit request to hold IF/ID register.
REQ-007 branch_taken  in  1  redirect request from EX.
REQ-008 branch_target  in  32  redirect PC.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  32  fetch address, word aligned.
REQ-011 imem_ready  in  1  memory response valid this cycle for the presented address.
REQ-012 imem_rdata  in  32  instruction word; valid only when imem_req & imem_ready.
REQ-013 pc_IF_ID  out  32  PC of the instruction held in IF/ID.
REQ-014 inst_IF_ID  out  32  instruction held in IF/ID.
REQ-015 valid_IF_ID  out  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-016 hold = pc_stall | ifid_stall; both inputs SHALL be treated identically.
REQ-017 States: FETCH, HOLD, DRAIN; 2-bit registered state.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ready & !hold & !branch_taken -> IF/ID <= {pc, imem_rdata, valid=1}, pc <= pc+4, stay FETCH.
REQ-019 FETCH, imem_ready & hold & !branch_taken: capture imem_rdata into one-entry skid buffer, go HOLD; IF/ID unchanged; pc unchanged.
REQ-020 FETCH, !imem_ready & !branch_taken: IF/ID unchanged if hold, else IF/ID <= bubble (NOP_INST, valid=0); pc unchanged.
REQ-021 HOLD: imem_req=0; while hold, all state unchanged; when !hold -> IF/ID <= {pc, buffer, valid=1}, pc <= pc+4, go FETCH.
REQ-022 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-023 branch_taken in FETCH with imem_ready=1 or in HOLD: pc <= branch_target, IF/ID <= bubble, buffer discarded, go FETCH, next cycle.
REQ-024 branch_taken in FETCH with imem_ready=0: pc <= branch_target, IF/ID <= bubble, go DRAIN; imem_addr keeps old address (REQ-022) via separate pending-address register.
REQ-025 DRAIN: imem_req=1 with old address; on imem_ready, data discarded, go FETCH; IF/ID stays bubble; later branch_taken in DRAIN updates pc only.
REQ-026 branch_taken SHALL override hold in every state (flush wins over stall).
REQ-027 pc arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0; branch_target[1:0] ignored (forced 0).
REQ-028 Latency: with imem_ready tied 1 and no hold, one instruction per cycle; IF/ID valid one edge after address presented.

Reset
REQ-029 On rst=1 at clock edge: pc=RESET_PC, state=FETCH, pc_IF_ID=0, inst_IF_ID=NOP_INST, valid_IF_ID=0, buffer cleared, counters 0.
REQ-030 rst SHALL override all other inputs, including mid-wait and DRAIN; an in-flight response after reset SHALL be accepted as response for RESET_PC only if memory is reset with the core.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: when defined, add outputs stall_cycles (out 32, cycles with hold=1 and rst=0) and fetch_count (out 32, instructions written valid into IF/ID); both wrap at 2^32.
REQ-032 Without FETCH_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, imem_ready=1, no hold, 4 cycles -> pc_IF_ID 0,4,8,C, valid=1 each cycle.
REQ-034 ready=1, hold=1 for 3 cycles at pc=8 -> state HOLD, IF/ID frozen at pc 4; hold released -> pc_IF_ID=8 with buffered word, imem_req=0 during HOLD.
REQ-035 branch_taken=1, target 32'h100, same cycle as hold=1 -> next cycle imem_addr=100, valid_IF_ID=0, state FETCH.
REQ-036 imem_ready=0 at addr 10, branch_taken target 200 -> imem_addr stays 10 until ready, response discarded, then imem_addr=200; no valid IF/ID entry for 10.
REQ-037 Branch target 32'hFFFF_FFFC, no hold -> following fetch address 0.
REQ-038 With FETCH_PERF_CNT_EN: 5 fetches + 2 hold cycles -> fetch_count=5, stall_cycles=2; rst clears both.
